// File: rtl/yolo_params_pkg.sv
// yolo_params_pkg: shared sizing constants and types for the convolution output path.
package yolo_params_pkg;
    localparam int IP_DATA_WIDTH  = 8;
    localparam int OFMAP_SIZE     = 4;
    localparam int OFMAP_ELEMS    = OFMAP_SIZE * OFMAP_SIZE;
    localparam int QSHIFT_DEFAULT = 4;
    typedef logic [2*IP_DATA_WIDTH-1:0] ofmap_word_t;
    typedef enum logic {TX_IDLE, TX_STREAM} ofmap_tx_state_e;
endpackage

// File: rtl/requant_sat.sv
// requant_sat: unsigned logical right shift followed by saturation to OUT_W bits.
module requant_sat #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_q
);
    logic [IN_W-1:0] w_sh;
    assign w_sh = i_data >> SHIFT;
    assign o_q  = |w_sh[IN_W-1:OUT_W] ? '1 : w_sh[OUT_W-1:0];
endmodule

// File: rtl/ofmap_stream_tx.sv
// ofmap_stream_tx: captures a full ofmap frame and streams it row-major over valid/ready
// with a raw and a requantized copy of each element.
module ofmap_stream_tx #(
    parameter int IP_DATA_WIDTH = yolo_params_pkg::IP_DATA_WIDTH,
    parameter int OFMAP_SIZE    = yolo_params_pkg::OFMAP_SIZE,
    parameter int QSHIFT        = yolo_params_pkg::QSHIFT_DEFAULT,
    localparam int IDX_W        = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [2*IP_DATA_WIDTH-1:0]   result_matrix [OFMAP_SIZE][OFMAP_SIZE],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*IP_DATA_WIDTH-1:0]   out_data,
    output logic [IP_DATA_WIDTH-1:0]     out_q,
    output logic [IDX_W-1:0]             out_row,
    output logic [IDX_W-1:0]             out_col,
    output logic                         out_last,
    output logic [15:0]                  frame_cnt
);
    import yolo_params_pkg::*;

    localparam int LAST = OFMAP_SIZE - 1;

    ofmap_tx_state_e             r_state, w_next;
    logic [IDX_W-1:0]            r_row, r_col;
    logic [15:0]                 r_frame_cnt;
    logic [2*IP_DATA_WIDTH-1:0]  r_buf [OFMAP_SIZE][OFMAP_SIZE];
    logic                        w_stream, w_load, w_beat, w_col_end, w_last_pos;

    assign w_stream   = r_state == TX_STREAM;
    assign w_load     = !w_stream && load_valid;
    assign w_beat     = w_stream && out_ready;
    assign w_col_end  = r_col == IDX_W'(LAST);
    assign w_last_pos = w_col_end && r_row == IDX_W'(LAST);

    always_comb begin
        w_next = r_state;
        if (w_load)
            w_next = TX_STREAM;
        else if (w_beat && w_last_pos)
            w_next = TX_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= TX_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_beat) begin
                r_col <= w_col_end ? '0 : r_col + 1'b1;
                if (w_col_end)
                    r_row <= w_last_pos ? '0 : r_row + 1'b1;
                if (w_last_pos)
                    r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Frame buffer needs no reset: it is only read after a capture.
    always_ff @(posedge clk) begin
        if (w_load)
            r_buf <= result_matrix;
    end

    assign load_ready = !w_stream;
    assign out_valid  = w_stream;
    assign out_data   = w_stream ? r_buf[r_row][r_col] : '0;
    assign out_row    = r_row;
    assign out_col    = r_col;
    assign out_last   = w_stream && w_last_pos;
    assign frame_cnt  = r_frame_cnt;

    requant_sat #(
        .IN_W  (2*IP_DATA_WIDTH),
        .OUT_W (IP_DATA_WIDTH),
        .SHIFT (QSHIFT)
    ) u_requant (
        .i_data (out_data),
        .o_q    (out_q)
    );
endmodule
